udma_uart_cfg_ctrl: RTL and testbench

//  Sys-clock sequencer for safe run-time reconfiguration of the uDMA UART. It accepts one config request,

---
 rtl/udma_uart_pkg.sv | 21 ++
 rtl/udma_uart_cfg_ctrl.sv | 152 +++++++++++++++
 tb/tb_udma_uart_cfg_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/udma_uart_pkg.sv
// rtl/udma_uart_pkg.sv - shared types for the uDMA UART config sequencer
package udma_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      DISABLE,
      APPLY,
      ENABLE
   } cfg_state_e;

   typedef struct packed {
      logic [15:0] div;
      logic [1:0]  bits;
      logic        parity_en;
      logic        stop_bits;
      logic        en_tx;
      logic        en_rx;
   } uart_cfg_t;

endpackage

// File: rtl/udma_uart_cfg_ctrl.sv
// rtl/udma_uart_cfg_ctrl.sv - sys-clock sequencer for safe run-time UART reconfiguration
module udma_uart_cfg_ctrl
   import udma_uart_pkg::*;
#(
   parameter int IDLE_STABLE    = 4,
   parameter int EN_LOW_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        sys_clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [15:0] req_div_i,
   input  logic [1:0]  req_bits_i,
   input  logic        req_parity_en_i,
   input  logic        req_stop_bits_i,
   input  logic        req_en_tx_i,
   input  logic        req_en_rx_i,
   input  logic        req_force_i,
   input  logic        tx_busy_i,
   input  logic        rx_busy_i,
   input  logic        tx_pending_i,
   output logic [15:0] divider_o,
   output logic [1:0]  num_bits_o,
   output logic        parity_en_o,
   output logic        stop_bits_o,
   output logic        en_tx_o,
   output logic        en_rx_o,
   output logic        done_o,
   output logic        busy_o,
   output logic        err_o,
   input  logic        err_clr_i
);

   localparam int CNT_MAX = (IDLE_STABLE > EN_LOW_CYCLES) ? IDLE_STABLE : EN_LOW_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_STABLE - 1);
   localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(EN_LOW_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   cfg_state_e       state;
   uart_cfg_t        req_q;
   uart_cfg_t        cfg_q;
   logic [CNT_W-1:0] stable_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             done_q;
   logic             err_q;
   logic             status_idle;

   assign status_idle = !(tx_busy_i || rx_busy_i || tx_pending_i);

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         req_q      <= '0;
         cfg_q      <= '0;
         stable_cnt <= '0;
         tmo_cnt    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // A timeout in the same cycle overrides this clear further down.
         if (err_clr_i) begin
            err_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  req_q <= '{div:       req_div_i,
                             bits:      req_bits_i,
                             parity_en: req_parity_en_i,
                             stop_bits: req_stop_bits_i,
                             en_tx:     req_en_tx_i,
                             en_rx:     req_en_rx_i};
                  stable_cnt <= '0;
                  tmo_cnt    <= '0;
                  if (req_force_i) begin
                     state       <= DISABLE;
                     cfg_q.en_tx <= 1'b0;
                     cfg_q.en_rx <= 1'b0;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
               if (!status_idle) begin
                  stable_cnt <= '0;
               end else if (stable_cnt != '1) begin
                  stable_cnt <= stable_cnt + 1'b1;
               end

               if (tmo_cnt == TMO_LAST || (status_idle && stable_cnt == IDLE_LAST)) begin
                  if (tmo_cnt == TMO_LAST) begin
                     err_q <= 1'b1;
                  end
                  state       <= DISABLE;
                  stable_cnt  <= '0;
                  cfg_q.en_tx <= 1'b0;
                  cfg_q.en_rx <= 1'b0;
               end
            end

            // The shared counter now times how long both enables stay low.
            DISABLE: begin
               if (stable_cnt == LOW_LAST) begin
                  state <= APPLY;
               end else if (stable_cnt != '1) begin
                  stable_cnt <= stable_cnt + 1'b1;
               end
            end

            APPLY: begin
               cfg_q.div       <= req_q.div;
               cfg_q.bits      <= req_q.bits;
               cfg_q.parity_en <= req_q.parity_en;
               cfg_q.stop_bits <= req_q.stop_bits;
               state           <= ENABLE;
            end

            ENABLE: begin
               cfg_q.en_tx <= req_q.en_tx;
               cfg_q.en_rx <= req_q.en_rx;
               done_q      <= 1'b1;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready_o = (state == IDLE);
   assign busy_o      = (state != IDLE);
   assign divider_o   = cfg_q.div;
   assign num_bits_o  = cfg_q.bits;
   assign parity_en_o = cfg_q.parity_en;
   assign stop_bits_o = cfg_q.stop_bits;
   assign en_tx_o     = cfg_q.en_tx;
   assign en_rx_o     = cfg_q.en_rx;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_udma_uart_cfg_ctrl.sv
// tb/tb_udma_uart_cfg_ctrl.sv - directed self-checking bench for udma_uart_cfg_ctrl
module tb_udma_uart_cfg_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, t_valid;
   logic [15:0] req_div;
   logic [1:0]  req_bits;
   logic        req_parity_en, req_stop_bits, req_en_tx, req_en_rx, req_force;
   logic        tx_busy, rx_busy, tx_pending, err_clr;
   logic        t_tx_busy, t_rx_busy, t_pending;

   logic        ready, en_tx, en_rx, done, busy, err, parity_en, stop_bits;
   logic [15:0] divider;
   logic [1:0]  num_bits;

   logic        t_ready, t_en_tx, t_en_rx, t_done, t_busy, t_err, t_parity_en, t_stop_bits;
   logic [15:0] t_divider;
   logic [1:0]  t_num_bits;

   int comp = 0;
   int fails = 0;

   always #5 clk = ~clk;

   udma_uart_cfg_ctrl dut (
      .sys_clk_i(clk), .rstn_i(rstn),
      .req_valid_i(req_valid), .req_ready_o(ready),
      .req_div_i(req_div), .req_bits_i(req_bits), .req_parity_en_i(req_parity_en),
      .req_stop_bits_i(req_stop_bits), .req_en_tx_i(req_en_tx), .req_en_rx_i(req_en_rx),
      .req_force_i(req_force),
      .tx_busy_i(tx_busy), .rx_busy_i(rx_busy), .tx_pending_i(tx_pending),
      .divider_o(divider), .num_bits_o(num_bits), .parity_en_o(parity_en), .stop_bits_o(stop_bits),
      .en_tx_o(en_tx), .en_rx_o(en_rx), .done_o(done), .busy_o(busy), .err_o(err),
      .err_clr_i(err_clr)
   );

   udma_uart_cfg_ctrl #(.TIMEOUT_CYCLES(32)) dut_tmo (
      .sys_clk_i(clk), .rstn_i(rstn),
      .req_valid_i(t_valid), .req_ready_o(t_ready),
      .req_div_i(req_div), .req_bits_i(req_bits), .req_parity_en_i(req_parity_en),
      .req_stop_bits_i(req_stop_bits), .req_en_tx_i(req_en_tx), .req_en_rx_i(req_en_rx),
      .req_force_i(req_force),
      .tx_busy_i(t_tx_busy), .rx_busy_i(t_rx_busy), .tx_pending_i(t_pending),
      .divider_o(t_divider), .num_bits_o(t_num_bits), .parity_en_o(t_parity_en), .stop_bits_o(t_stop_bits),
      .en_tx_o(t_en_tx), .en_rx_o(t_en_rx), .done_o(t_done), .busy_o(t_busy), .err_o(t_err),
      .err_clr_i(err_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      comp++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [15:0] d, input logic [1:0] b, input logic p, input logic s,
                          input logic etx, input logic erx, input logic frc);
      req_div       = d;
      req_bits      = b;
      req_parity_en = p;
      req_stop_bits = s;
      req_en_tx     = etx;
      req_en_rx     = erx;
      req_force     = frc;
   endtask

   initial begin
      rstn = 1'b0;
      req_valid = 1'b0; t_valid = 1'b0;
      set_req(16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tx_busy = 1'b0; rx_busy = 1'b0; tx_pending = 1'b0; err_clr = 1'b0;
      t_tx_busy = 1'b0; t_rx_busy = 1'b0; t_pending = 1'b0;
      tick();
      tick();

      check("rst_divider", divider, 32'h0);
      check("rst_en_tx", en_tx, 0);
      check("rst_en_rx", en_rx, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_ready", ready, 1);
      rstn = 1'b1;
      tick();

      // idle UART: done 14 cycles after accept, cfg lands one cycle before the enable
      set_req(16'h00A2, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("t1_busy", busy, 1);
      check("t1_ready", ready, 0);
      for (int n = 1; n <= 14; n++) begin
         tick();
         if (n == 12) check("t1_div_before_apply", divider, 32'h0);
         if (n == 13) begin
            check("t1_div_applied", divider, 32'h00A2);
            check("t1_bits_applied", num_bits, 3);
            check("t1_en_tx_still_low", en_tx, 0);
            check("t1_done_early", done, 0);
         end
      end
      check("t1_done", done, 1);
      check("t1_en_tx", en_tx, 1);
      check("t1_en_rx", en_rx, 0);
      check("t1_busy_end", busy, 0);
      tick();
      check("t1_done_pulse", done, 0);

      // TX busy for 100 cycles after accept holds the sequence in drain
      tx_busy = 1'b1;
      set_req(16'h1234, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int n = 1; n <= 114; n++) begin
         tick();
         tx_busy = (n < 100);
         if (n == 50)  check("t2_ready_low", ready, 0);
         if (n == 103) check("t2_en_tx_drain", en_tx, 1);
         if (n == 104) check("t2_en_tx_drop", en_tx, 0);
         if (n == 112) check("t2_en_tx_low", en_tx, 0);
         if (n == 113) begin
            check("t2_div", divider, 32'h1234);
            check("t2_parity", parity_en, 1);
            check("t2_stop", stop_bits, 1);
            check("t2_en_rx_low", en_rx, 0);
         end
      end
      check("t2_done", done, 1);
      check("t2_en_tx", en_tx, 1);
      check("t2_en_rx", en_rx, 1);

      // forced request skips drain even with RX busy
      rx_busy = 1'b1;
      set_req(16'h0055, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("t3_en_tx_low", en_tx, 0);
      check("t3_en_rx_low", en_rx, 0);
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (n == 8) check("t3_div_old", divider, 32'h1234);
         if (n == 9) check("t3_div_new", divider, 32'h0055);
         if (n == 9) check("t3_done_early", done, 0);
      end
      check("t3_done", done, 1);
      check("t3_en_tx", en_tx, 0);
      check("t3_en_rx", en_rx, 1);
      rx_busy = 1'b0;
      req_force = 1'b0;

      // held valid: second request only after done, with its own enable-low window
      set_req(16'h0300, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      req_valid = 1'b1;
      tick();
      for (int n = 1; n <= 29; n++) begin
         tick();
         if (n == 13) check("t4_ready_low", ready, 0);
         if (n == 14) begin
            check("t4_done1", done, 1);
            check("t4_ready_high", ready, 1);
            check("t4_en_tx1", en_tx, 1);
         end
         if (n == 15) check("t4_busy2", busy, 1);
         if (n == 18) check("t4_en_tx_pre", en_tx, 1);
         if (n == 19) check("t4_en_tx_drop2", en_tx, 0);
         if (n == 28) check("t4_done_early", done, 0);
      end
      req_valid = 1'b0;
      check("t4_done2", done, 1);
      check("t4_en_rx2", en_rx, 1);

      // both enables zero: cfg still applied, UART left disabled
      set_req(16'h0777, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         tick();
         if (n == 3) check("t5_en_tx_pre", en_tx, 1);
         if (n == 4) check("t5_en_tx_drop", en_tx, 0);
      end
      check("t5_done", done, 1);
      check("t5_en_tx", en_tx, 0);
      check("t5_en_rx", en_rx, 0);
      check("t5_div", divider, 32'h0777);
      check("t5_stop", stop_bits, 1);

      // async reset while in DISABLE, then a clean sequence
      set_req(16'h0ABC, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int n = 1; n <= 6; n++) tick();
      check("t6_busy_pre", busy, 1);
      #2;
      rstn = 1'b0;
      #1;
      check("t6_rst_div", divider, 32'h0);
      check("t6_rst_stop", stop_bits, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_ready", ready, 1);
      check("t6_rst_en_tx", en_tx, 0);
      tick();
      rstn = 1'b1;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int n = 1; n <= 14; n++) tick();
      check("t6_done", done, 1);
      check("t6_div", divider, 32'h0ABC);
      check("t6_parity", parity_en, 1);
      check("t6_en_tx", en_tx, 1);
      check("t6_en_rx", en_rx, 1);

      // drain timeout with TIMEOUT_CYCLES=32 and a toggling busy
      check("t7_err_init", t_err, 0);
      set_req(16'h0020, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      t_tx_busy = 1'b1;
      t_valid = 1'b1;
      tick();
      t_valid = 1'b0;
      for (int n = 1; n <= 42; n++) begin
         tick();
         t_tx_busy = ((n / 2) % 2 == 0);
         if (n == 31) begin
            check("t7_err_before", t_err, 0);
            err_clr = 1'b1;
         end
         if (n == 32) begin
            check("t7_err_set_wins", t_err, 1);
            err_clr = 1'b0;
         end
         if (n == 41) check("t7_div", t_divider, 32'h0020);
      end
      check("t7_done", t_done, 1);
      check("t7_err_sticky", t_err, 1);
      check("t7_en_tx", t_en_tx, 1);
      t_tx_busy = 1'b0;

      // a pending error does not block the next request
      check("t7_ready_with_err", t_ready, 1);
      set_req(16'h0041, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      t_valid = 1'b1;
      tick();
      t_valid = 1'b0;
      check("t7_busy2", t_busy, 1);
      for (int n = 1; n <= 14; n++) tick();
      check("t7_done2", t_done, 1);
      check("t7_div2", t_divider, 32'h0041);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t7_err_cleared", t_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, fails);
      $finish;
   end

endmodule
